// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory access sequencer:
// FSM states, FUNC3 width codes, byte-lane patterns and request legality.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] BE_B    = 4'b0001;
    localparam logic [3:0] BE_H_LO = 4'b0011;
    localparam logic [3:0] BE_H_HI = 4'b1100;
    localparam logic [3:0] BE_W    = 4'b1111;

    // Unsigned widths exist only for loads; halves and words must be naturally aligned.
    function automatic logic access_legal(input logic is_load, input logic [2:0] f3,
                                          input logic [1:0] off);
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = ~off[0];
            F3_W:    ok = (off == 2'b00);
            F3_BU:   ok = is_load;
            F3_HU:   ok = is_load & ~off[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] byte_enable(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = BE_B << off;
            2'b01:   be = off[1] ? BE_H_HI : BE_H_LO;
            default: be = BE_W;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] lanes;
        case (f3[1:0])
            2'b00:   lanes = {4{wd[7:0]}};
            2'b01:   lanes = {2{wd[15:0]}};
            default: lanes = wd;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load formatter: picks the addressed byte/half from the memory word and
// sign- or zero-extends it according to FUNC3. Purely combinational.
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  func3,
    output logic [31:0] result
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = rdata[{off, 3'b000} +: 8];
        lane_h = off[1] ? rdata[31:16] : rdata[15:0];
        case (func3)
            F3_B:    result = {{24{lane_b[7]}}, lane_b};
            F3_H:    result = {{16{lane_h[15]}}, lane_h};
            F3_BU:   result = {24'h0, lane_b};
            F3_HU:   result = {16'h0, lane_h};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/dmem_access_controller.sv
// Multi-cycle MEM-stage data-memory sequencer (IDLE -> ACCESS -> DONE).
// Optional ACK watchdog enabled by defining DMEM_TIMEOUT_EN.
module dmem_access_controller
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  CLK,
    input  logic                  RESETN,
    input  logic                  MEM_READ,
    input  logic                  MEM_WRITE,
    input  logic [2:0]            FUNC3,
    input  logic [ADDR_WIDTH-1:0] ADDRESS,
    input  logic [31:0]           WRITE_DATA,
    output logic [31:0]           READ_DATA,
    output logic                  BUSY_WAIT,
    output logic                  ACCESS_FAULT,
    output logic                  MEM_REQ,
    output logic                  MEM_WE,
    output logic [ADDR_WIDTH-1:0] MEM_ADDR,
    output logic [3:0]            MEM_BYTE_EN,
    output logic [31:0]           MEM_WDATA,
    input  logic [31:0]           MEM_RDATA,
    input  logic                  MEM_ACK
);

    state_t      state, state_nx;
    logic        req_in, is_load, legal, fault_q, timeout;
    logic [2:0]  func3_q;
    logic [1:0]  off_q;
    logic [31:0] load_data;

    assign req_in  = MEM_READ | MEM_WRITE;
    assign is_load = MEM_READ;
    assign legal   = access_legal(is_load, FUNC3, ADDRESS[1:0]);

    dmem_load_align u_align (
        .rdata  (MEM_RDATA),
        .off    (off_q),
        .func3  (func3_q),
        .result (load_data)
    );

`ifdef DMEM_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] wait_cnt;

    // The limit fires on the TIMEOUT_CYCLES-th ACCESS cycle without ACK.
    assign timeout = (state == ACCESS) && !MEM_ACK &&
                     (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN)
            wait_cnt <= '0;
        else if (state != ACCESS)
            wait_cnt <= '0;
        else if (!MEM_ACK)
            wait_cnt <= wait_cnt + 1'b1;
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req_in) state_nx = legal ? ACCESS : DONE;
            ACCESS:  if (MEM_ACK || timeout) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // The stall is gated by reset so it drops the instant reset is asserted.
    always_comb begin
        BUSY_WAIT    = 1'b0;
        ACCESS_FAULT = 1'b0;
        case (state)
            IDLE:    BUSY_WAIT = RESETN & req_in;
            ACCESS:  BUSY_WAIT = 1'b1;
            DONE:    ACCESS_FAULT = fault_q;
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            MEM_REQ     <= 1'b0;
            MEM_WE      <= 1'b0;
            MEM_ADDR    <= '0;
            MEM_BYTE_EN <= 4'h0;
            MEM_WDATA   <= 32'h0;
            READ_DATA   <= 32'h0;
            fault_q     <= 1'b0;
            func3_q     <= 3'b000;
            off_q       <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (req_in && legal) begin
                        MEM_REQ     <= 1'b1;
                        MEM_WE      <= ~is_load;
                        MEM_ADDR    <= {ADDRESS[ADDR_WIDTH-1:2], 2'b00};
                        MEM_BYTE_EN <= byte_enable(FUNC3, ADDRESS[1:0]);
                        MEM_WDATA   <= store_lanes(FUNC3, WRITE_DATA);
                        func3_q     <= FUNC3;
                        off_q       <= ADDRESS[1:0];
                    end else if (req_in) begin
                        fault_q <= 1'b1;
                        if (is_load)
                            READ_DATA <= 32'h0;
                    end
                end
                ACCESS: begin
                    if (MEM_ACK) begin
                        MEM_REQ <= 1'b0;
                        if (!MEM_WE)
                            READ_DATA <= load_data;
                    end else if (timeout) begin
                        MEM_REQ   <= 1'b0;
                        fault_q   <= 1'b1;
                        READ_DATA <= 32'h0;
                    end
                end
                DONE:    fault_q <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_controller.sv
// Scoreboard bench for dmem_access_controller: directed transactions push
// expected results; a negedge monitor checks each completion.
module tb_dmem_access_controller;

    logic        CLK = 1'b0;
    logic        RESETN = 1'b0;
    logic        MEM_READ = 1'b0;
    logic        MEM_WRITE = 1'b0;
    logic [2:0]  FUNC3 = 3'b000;
    logic [31:0] ADDRESS = 32'h0;
    logic [31:0] WRITE_DATA = 32'h0;
    logic [31:0] READ_DATA;
    logic        BUSY_WAIT;
    logic        ACCESS_FAULT;
    logic        MEM_REQ;
    logic        MEM_WE;
    logic [31:0] MEM_ADDR;
    logic [3:0]  MEM_BYTE_EN;
    logic [31:0] MEM_WDATA;
    logic [31:0] MEM_RDATA = 32'h0;
    logic        MEM_ACK = 1'b0;

    always #5 CLK = ~CLK;

    dmem_access_controller #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(64)) dut (
        .CLK          (CLK),
        .RESETN       (RESETN),
        .MEM_READ     (MEM_READ),
        .MEM_WRITE    (MEM_WRITE),
        .FUNC3        (FUNC3),
        .ADDRESS      (ADDRESS),
        .WRITE_DATA   (WRITE_DATA),
        .READ_DATA    (READ_DATA),
        .BUSY_WAIT    (BUSY_WAIT),
        .ACCESS_FAULT (ACCESS_FAULT),
        .MEM_REQ      (MEM_REQ),
        .MEM_WE       (MEM_WE),
        .MEM_ADDR     (MEM_ADDR),
        .MEM_BYTE_EN  (MEM_BYTE_EN),
        .MEM_WDATA    (MEM_WDATA),
        .MEM_RDATA    (MEM_RDATA),
        .MEM_ACK      (MEM_ACK)
    );

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic        chk_wd;
        logic [31:0] wd;
        logic        chk_rd;
        logic [31:0] rd;
        logic        fault;
        int          busy;
    } exp_t;

    exp_t sb[$];
    exp_t me;
    int   tests = 0;
    int   fails = 0;
    int   txn_id = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: records request-side outputs and checks each completion (DONE cycle).
    logic        prev_busy = 1'b0;
    logic        prev_req = 1'b0;
    int          busy_cnt = 0;
    int          rises = 0;
    logic [31:0] cap_addr = 32'h0;
    logic [31:0] cap_wd = 32'h0;
    logic [3:0]  cap_be = 4'h0;
    logic        cap_we = 1'b0;

    always @(negedge CLK) begin
        if (!RESETN) begin
            prev_busy = 1'b0;
            prev_req  = 1'b0;
            busy_cnt  = 0;
            rises     = 0;
        end else begin
            if (MEM_REQ) begin
                cap_addr = MEM_ADDR;
                cap_wd   = MEM_WDATA;
                cap_be   = MEM_BYTE_EN;
                cap_we   = MEM_WE;
                if (!prev_req) rises++;
            end
            prev_req = MEM_REQ;
            if (ACCESS_FAULT && !(prev_busy && !BUSY_WAIT))
                check32("fault_outside_done", ACCESS_FAULT, 32'h0);
            if (BUSY_WAIT) begin
                busy_cnt++;
            end else if (prev_busy) begin
                if (sb.size() == 0) begin
                    check32("unexpected_completion", 32'h1, 32'h0);
                end else begin
                    me = sb.pop_front();
                    txn_id++;
                    check32($sformatf("t%0d_fault", txn_id), {31'h0, ACCESS_FAULT}, {31'h0, me.fault});
                    check32($sformatf("t%0d_busy_cycles", txn_id), busy_cnt, me.busy);
                    check32($sformatf("t%0d_req_count", txn_id), rises, {31'h0, me.req});
                    check32($sformatf("t%0d_req_low_done", txn_id), {31'h0, MEM_REQ}, 32'h0);
                    if (me.req) begin
                        check32($sformatf("t%0d_addr", txn_id), cap_addr, me.addr);
                        check32($sformatf("t%0d_byte_en", txn_id), {28'h0, cap_be}, {28'h0, me.be});
                        check32($sformatf("t%0d_we", txn_id), {31'h0, cap_we}, {31'h0, me.we});
                        if (me.chk_wd)
                            check32($sformatf("t%0d_wdata", txn_id), cap_wd, me.wd);
                    end
                    if (me.chk_rd)
                        check32($sformatf("t%0d_read_data", txn_id), READ_DATA, me.rd);
                end
                busy_cnt = 0;
                rises    = 0;
            end
            prev_busy = BUSY_WAIT;
        end
    end

    // waits < 0: never ACK, wait (bounded) for the controller to give up.
    task automatic do_txn(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdata,
                          input int waits, input logic e_req, input logic [3:0] e_be,
                          input logic [31:0] e_wd, input logic e_chkrd, input logic [31:0] e_rd,
                          input logic e_fault, input int e_busy);
        exp_t e;
        int   n;
        e.req = e_req;  e.addr = {a[31:2], 2'b00};  e.be = e_be;  e.we = ~rd;
        e.chk_wd = wr & ~rd;  e.wd = e_wd;  e.chk_rd = e_chkrd;  e.rd = e_rd;
        e.fault = e_fault;  e.busy = e_busy;
        sb.push_back(e);
        @(posedge CLK); #1;
        MEM_READ = rd;  MEM_WRITE = wr;  FUNC3 = f3;  ADDRESS = a;  WRITE_DATA = wd;
        @(posedge CLK); #1;
        if (waits < 0) begin
            n = 0;
            while (BUSY_WAIT && n < 300) begin
                @(posedge CLK); #1;
                n++;
            end
            if (n >= 300) check32("wait_budget_expired", 32'h1, 32'h0);
        end else if (MEM_REQ) begin
            repeat (waits) begin @(posedge CLK); #1; end
            MEM_ACK = 1'b1;  MEM_RDATA = rdata;
            @(posedge CLK); #1;
            MEM_ACK = 1'b0;  MEM_RDATA = 32'h0;
        end
    endtask

    task automatic idle(input int n, input logic ack);
        @(posedge CLK); #1;
        MEM_READ = 1'b0;  MEM_WRITE = 1'b0;  MEM_ACK = ack;
        repeat (n) begin
            @(posedge CLK); #1;
            if (ack) begin
                check32("ack_in_idle_busy", {31'h0, BUSY_WAIT}, 32'h0);
                check32("ack_in_idle_req", {31'h0, MEM_REQ}, 32'h0);
            end
        end
        MEM_ACK = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        check32("rst_mem_req", {31'h0, MEM_REQ}, 32'h0);
        check32("rst_busy", {31'h0, BUSY_WAIT}, 32'h0);
        check32("rst_fault", {31'h0, ACCESS_FAULT}, 32'h0);
        check32("rst_read_data", READ_DATA, 32'h0);
        check32("rst_mem_addr", MEM_ADDR, 32'h0);
        check32("rst_byte_en", {28'h0, MEM_BYTE_EN}, 32'h0);
        check32("rst_wdata", MEM_WDATA, 32'h0);
        check32("rst_we", {31'h0, MEM_WE}, 32'h0);
        RESETN = 1'b1;

        do_txn(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 1, 4'hF, 32'hDEADBEEF, 1, 32'h0, 0, 2);
        idle(2, 1'b0);
        do_txn(1, 0, 3'b000, 32'h203, 32'h0, 32'h80FF1234, 3, 1, 4'h8, 32'h0, 1, 32'hFFFFFF80, 0, 5);
        idle(1, 1'b0);
        do_txn(1, 0, 3'b100, 32'h203, 32'h0, 32'h80FF1234, 3, 1, 4'h8, 32'h0, 1, 32'h00000080, 0, 5);
        idle(1, 1'b0);
        do_txn(1, 0, 3'b000, 32'h201, 32'h0, 32'h80FF1234, 0, 1, 4'h2, 32'h0, 1, 32'h00000012, 0, 2);
        idle(1, 1'b0);
        do_txn(1, 0, 3'b001, 32'h102, 32'h0, 32'h8001ABCD, 0, 1, 4'hC, 32'h0, 1, 32'hFFFF8001, 0, 2);
        idle(1, 1'b0);
        do_txn(1, 0, 3'b101, 32'h100, 32'h0, 32'h8001ABCD, 1, 1, 4'h3, 32'h0, 1, 32'h0000ABCD, 0, 3);
        idle(1, 1'b0);
        do_txn(0, 1, 3'b001, 32'h101, 32'h1234, 32'h0, 0, 0, 4'h0, 32'h0, 0, 32'h0, 1, 1);
        idle(1, 1'b0);
        do_txn(1, 0, 3'b010, 32'h102, 32'h0, 32'hFFFFFFFF, 0, 0, 4'h0, 32'h0, 1, 32'h0, 1, 1);
        idle(1, 1'b0);
        do_txn(1, 0, 3'b011, 32'h0, 32'h0, 32'hFFFFFFFF, 0, 0, 4'h0, 32'h0, 1, 32'h0, 1, 1);
        idle(1, 1'b0);
        do_txn(0, 1, 3'b100, 32'h0, 32'h77, 32'h0, 0, 0, 4'h0, 32'h0, 0, 32'h0, 1, 1);
        idle(1, 1'b0);
        do_txn(0, 1, 3'b001, 32'h102, 32'h5555BEEF, 32'h0, 1, 1, 4'hC, 32'hBEEFBEEF, 0, 32'h0, 0, 3);
        idle(1, 1'b0);
        do_txn(1, 1, 3'b010, 32'h40, 32'hCAFEF00D, 32'h0BADF00D, 0, 1, 4'hF, 32'h0, 1, 32'h0BADF00D, 0, 2);
        idle(3, 1'b1);
        do_txn(0, 1, 3'b000, 32'h3, 32'hAA, 32'h0, 0, 1, 4'h8, 32'hAAAAAAAA, 0, 32'h0, 0, 2);
        do_txn(1, 0, 3'b010, 32'h0, 32'h0, 32'h12345678, 0, 1, 4'hF, 32'h0, 1, 32'h12345678, 0, 2);
        idle(2, 1'b0);

        @(posedge CLK); #1;
        MEM_READ = 1'b1;  MEM_WRITE = 1'b0;  FUNC3 = 3'b010;  ADDRESS = 32'h10;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        check32("pre_reset_req", {31'h0, MEM_REQ}, 32'h1);
        RESETN = 1'b0;
        #1;
        check32("midrst_req", {31'h0, MEM_REQ}, 32'h0);
        check32("midrst_busy", {31'h0, BUSY_WAIT}, 32'h0);
        check32("midrst_fault", {31'h0, ACCESS_FAULT}, 32'h0);
        check32("midrst_addr", MEM_ADDR, 32'h0);
        check32("midrst_read_data", READ_DATA, 32'h0);
        MEM_READ = 1'b0;
        @(posedge CLK); #1;
        RESETN = 1'b1;
        idle(2, 1'b0);

        do_txn(0, 1, 3'b010, 32'h8, 32'h01020304, 32'h0, 0, 1, 4'hF, 32'h01020304, 1, 32'h0, 0, 2);
        idle(1, 1'b0);
`ifdef DMEM_TIMEOUT_EN
        do_txn(1, 0, 3'b000, 32'h21, 32'h0, 32'h0, 0, 1, 4'h2, 32'h0, 1, 32'h0, 0, 2);
        idle(1, 1'b0);
        do_txn(1, 0, 3'b010, 32'h20, 32'h0, 32'h0, -1, 1, 4'hF, 32'h0, 1, 32'h0, 1, 65);
        idle(1, 1'b0);
`endif
        idle(3, 1'b0);
        check32("scoreboard_empty", sb.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
